// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared FSM encoding, header tag and source IDs for the USB TX arbiter
package usb_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  localparam logic [1:0] SRC_CPU  = 2'd0;
  localparam logic [1:0] SRC_INA  = 2'd1;
  localparam logic [1:0] SRC_INB  = 2'd2;
  localparam logic [1:0] SRC_LOOP = 2'd3;

  // A burst_len field of zero stands for the maximum burst of 16 words.
  function automatic logic [4:0] burst_words(input logic [3:0] len);
    return (len == 4'd0) ? 5'd16 : {1'b0, len};
  endfunction

endpackage

// File: rtl/usb_tx_arb_if.sv
// rtl/usb_tx_arb_if.sv - source request and USB write FIFO signals of the TX arbiter
interface usb_tx_arb_if #(
  parameter int N_SRC = 4
);

  logic [N_SRC*32-1:0] src_data;
  logic [N_SRC-1:0]    src_valid;
  logic [N_SRC-1:0]    src_ready;
  logic [31:0]         fifo_wr_data;
  logic [3:0]          fifo_wr_be;
  logic                fifo_wr_en;
  logic                fifo_full;

  modport master (
    input  src_data, src_valid, fifo_full,
    output src_ready, fifo_wr_data, fifo_wr_be, fifo_wr_en
  );

  modport slave (
    output src_data, src_valid, fifo_full,
    input  src_ready, fifo_wr_data, fifo_wr_be, fifo_wr_en
  );

endinterface

// File: rtl/usb_tx_arb_rr_arbiter.sv
// rtl/usb_tx_arb_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [N-1:0] gnt_oh,
  output logic [1:0]   gnt_idx,
  output logic         gnt_any
);

  int idx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gnt_any && req[idx]) begin
        gnt_any     = 1'b1;
        gnt_idx     = idx[1:0];
        gnt_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_tx_arb.sv
// rtl/usb_tx_arb.sv - arbitrates source bursts into the USB write FIFO, each burst led by a header word
module usb_tx_arb #(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] HDR_MAGIC = usb_tx_pkg::HDR_MAGIC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         mode_fixed,
  input  logic [1:0]   src_sel,
  input  logic [3:0]   burst_len,
  output logic         busy,
  output logic [1:0]   cur_src,
  usb_tx_arb_if.master bus
);

  import usb_tx_pkg::*;

  state_t           state;
  logic [1:0]       rr_ptr;
  logic [4:0]       len;
  logic [4:0]       wcnt;
  logic [7:0]       seq;

  logic [N_SRC-1:0] req;
  logic [1:0]       ptr;
  logic [N_SRC-1:0] gnt_oh;
  logic [1:0]       gnt_idx;
  logic             gnt_any;

  logic             sel_valid;
  logic [31:0]      sel_data;
  logic             wr_en;
  logic [31:0]      wr_data;

  // Fixed mode reuses the arbiter: only src_sel may request, and the search starts there.
  always_comb begin
    req = bus.src_valid;
    ptr = rr_ptr;
    if (mode_fixed) begin
      req = '0;
      ptr = src_sel;
      for (int i = 0; i < N_SRC; i++) begin
        if (src_sel == i[1:0]) req[i] = bus.src_valid[i];
      end
    end
  end

  rr_arbiter #(.N(N_SRC)) u_rr_arbiter (
    .req     (req),
    .ptr     (ptr),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (cur_src == i[1:0]) begin
        sel_valid = bus.src_valid[i];
        sel_data  = bus.src_data[32*i +: 32];
      end
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    case (state)
      ST_HDR: begin
        wr_en   = ~bus.fifo_full;
        wr_data = {HDR_MAGIC, seq, 6'b0, cur_src, 3'b0, len};
      end
      ST_DATA: begin
        wr_en   = sel_valid & ~bus.fifo_full;
        wr_data = sel_data;
      end
      default: begin
        wr_en   = 1'b0;
        wr_data = '0;
      end
    endcase
  end

  always_comb begin
    bus.src_ready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      bus.src_ready[i] = (state == ST_DATA) && wr_en && (cur_src == i[1:0]);
    end
  end

  assign bus.fifo_wr_en   = wr_en;
  assign bus.fifo_wr_data = wr_data;
  assign bus.fifo_wr_be   = wr_en ? 4'hF : 4'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      rr_ptr  <= 2'd0;
      seq     <= 8'd0;
      wcnt    <= 5'd0;
      len     <= 5'd0;
      cur_src <= SRC_CPU;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && gnt_any && (gnt_oh != '0)) begin
            state   <= ST_HDR;
            busy    <= 1'b1;
            cur_src <= gnt_idx;
            len     <= burst_words(burst_len);
            wcnt    <= 5'd0;
            rr_ptr  <= (int'(gnt_idx) == N_SRC - 1) ? 2'd0 : gnt_idx + 2'd1;
          end
        end
        ST_HDR: begin
          if (!bus.fifo_full) begin
            seq   <= seq + 8'd1;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wr_en) begin
            if (wcnt + 5'd1 == len) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              wcnt  <= 5'd0;
            end else begin
              wcnt <= wcnt + 5'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_arb.sv
// tb/tb_usb_tx_arb.sv - directed self-checking bench for usb_tx_arb
module tb_usb_tx_arb;
  import usb_tx_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       mode_fixed = 1'b0;
  logic [1:0] src_sel = 2'd0;
  logic [3:0] burst_len = 4'd0;
  logic       busy;
  logic [1:0] cur_src;

  usb_tx_arb_if #(.N_SRC(4)) bus ();

  usb_tx_arb #(.N_SRC(4), .HDR_MAGIC(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode_fixed (mode_fixed),
    .src_sel    (src_sel),
    .burst_len  (burst_len),
    .busy       (busy),
    .cur_src    (cur_src),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          full_wr = 0;
  logic [7:0]  cnt [4];
  logic [31:0] wq [$];
  logic        s_wr_en;
  logic [3:0]  s_ready;
  logic [3:0]  s_be;
  logic [31:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int s, input int k);
    return {16'hC0DE, 8'(s), 8'(k)};
  endfunction

  // One clock: present source words, sample outputs, let the edge happen, advance consumed sources.
  task automatic tick();
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[32*i +: 32] = word(i, int'(cnt[i]));
    bus.src_data = d;
    #1;
    s_wr_en = bus.fifo_wr_en;
    s_ready = bus.src_ready;
    s_be    = bus.fifo_wr_be;
    s_data  = bus.fifo_wr_data;
    if (s_wr_en) wq.push_back(s_data);
    if (s_wr_en && bus.fifo_full) full_wr++;
    @(posedge clk);
    for (int i = 0; i < 4; i++) if (s_ready[i]) cnt[i] = cnt[i] + 8'd1;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    wq.delete();
    for (int i = 0; i < 4; i++) cnt[i] = 8'd0;
  endtask

  initial begin
    bus.src_valid = 4'hF;
    bus.fifo_full = 1'b0;
    bus.src_data  = '0;
    clr();
    enable = 1'b1;
    @(negedge clk);
    ticks(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cur_src", 32'(cur_src), 32'd0);
    chk("rst_wr_en", 32'(s_wr_en), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_be", 32'(s_be), 32'd0);
    chk("rst_data", s_data, 32'd0);

    // Fixed source 1, 4-word burst
    enable = 1'b0;
    reset = 1'b0;
    mode_fixed = 1'b1;
    src_sel = SRC_INA;
    burst_len = 4'd4;
    bus.src_valid = 4'b0010;
    clr();
    enable = 1'b1;
    tick();
    chk("fix_idle_wr", 32'(s_wr_en), 32'd0);
    tick();
    chk("fix_hdr", s_data, 32'hA500_0104);
    chk("fix_hdr_be", 32'(s_be), 32'hF);
    chk("fix_busy", 32'(busy), 32'd1);
    chk("fix_cur_src", 32'(cur_src), 32'd1);
    ticks(4);
    enable = 1'b0;
    ticks(2);
    chk("fix_count", wq.size(), 32'd5);
    for (int k = 0; k < 4; k++) chk("fix_word", wq[k+1], word(1, k));
    chk("fix_done_busy", 32'(busy), 32'd0);
    chk("fix_last_src", 32'(cur_src), 32'd1);
    burst_len = 4'd1;
    enable = 1'b1;
    ticks(2);
    chk("fix_seq1_hdr", s_data, 32'hA501_0101);
    enable = 1'b0;
    ticks(2);

    // Round-robin from reset, all valid, 2-word bursts
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mode_fixed = 1'b0;
    burst_len = 4'd2;
    bus.src_valid = 4'hF;
    clr();
    enable = 1'b1;
    ticks(20);
    enable = 1'b0;
    ticks(2);
    chk("rr_count", wq.size(), 32'd15);
    for (int b = 0; b < 5; b++) begin
      chk("rr_hdr", wq[3*b], {8'hA5, 8'(b), 8'(b % 4), 8'h02});
      chk("rr_w0", wq[3*b+1], word(b % 4, (b / 4) * 2));
      chk("rr_w1", wq[3*b+2], word(b % 4, (b / 4) * 2 + 1));
    end

    // fifo_full held for 3 cycles mid-burst
    mode_fixed = 1'b1;
    src_sel = SRC_INB;
    burst_len = 4'd4;
    bus.src_valid = 4'b0100;
    clr();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    ticks(3);
    bus.fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("full_wr_en", 32'(s_wr_en), 32'd0);
      chk("full_ready", 32'(s_ready), 32'd0);
    end
    chk("full_busy", 32'(busy), 32'd1);
    bus.fifo_full = 1'b0;
    ticks(3);
    chk("full_count", wq.size(), 32'd5);
    chk("full_hdr", wq[0], 32'hA505_0204);
    for (int k = 0; k < 4; k++) chk("full_word", wq[k+1], word(2, k));
    chk("full_idle", 32'(busy), 32'd0);

    // burst_len 0 means 16 words
    src_sel = SRC_LOOP;
    burst_len = 4'd0;
    bus.src_valid = 4'b1000;
    clr();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    ticks(19);
    chk("len16_count", wq.size(), 32'd17);
    chk("len16_hdr", wq[0], 32'hA506_0310);
    chk("len16_last", wq[16], word(3, 15));

    // Sequence wrap over many 1-word bursts
    src_sel = SRC_CPU;
    burst_len = 4'd1;
    bus.src_valid = 4'b0001;
    clr();
    enable = 1'b1;
    ticks(750);
    enable = 1'b0;
    ticks(2);
    chk("wrap_count", wq.size(), 32'd500);
    chk("wrap_hdr_ff", wq[496], 32'hA5FF_0001);
    chk("wrap_hdr_00", wq[498], 32'hA500_0001);

    // Source stalls mid-burst while enable is dropped
    src_sel = SRC_INA;
    burst_len = 4'd4;
    bus.src_valid = 4'b0010;
    clr();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    ticks(3);
    bus.src_valid = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_wr_en", 32'(s_wr_en), 32'd0);
    end
    chk("stall_busy", 32'(busy), 32'd1);
    bus.src_valid = 4'b0010;
    ticks(2);
    chk("stall_done", 32'(busy), 32'd0);
    ticks(3);
    chk("stall_no_new", 32'(busy), 32'd0);
    chk("stall_count", wq.size(), 32'd5);
    chk("stall_hdr", wq[0], 32'hA501_0104);
    chk("stall_w2", wq[3], word(1, 2));
    chk("stall_w3", wq[4], word(1, 3));

    // Reset in DATA after one word
    src_sel = SRC_INB;
    bus.src_valid = 4'b0100;
    clr();
    enable = 1'b1;
    ticks(3);
    chk("rmid_hdr", wq[0], 32'hA502_0204);
    reset = 1'b1;
    tick();
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_cur_src", 32'(cur_src), 32'd0);
    #1;
    chk("rmid_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    reset = 1'b0;
    ticks(2);
    chk("rmid_seq0", s_data, 32'hA500_0204);
    enable = 1'b0;
    ticks(5);

    chk("no_write_when_full", full_wr, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
